// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver with a show-ahead receive FIFO and sticky error flags.
// Optional macro UART_RX_PARITY_EN adds one even-parity bit after the data bits.
module uart_rx_capture #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              resetb,
    input  logic                              ser_rx,
    input  logic                              rd_en,
    input  logic                              clr_err,
    output logic [7:0]                        rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              frame_err,
    output logic                              overrun,
    output logic                              parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] HALF_LD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BIT_LD  = 16'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        push;
    logic        ferr_set;
    logic        ferr_q, ovr_q;
    logic        tick;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic          fifo_full, fifo_empty;
    logic          do_push, do_pop, ovr_set;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic perr_set;
    logic perr_q;
`endif

    // Two-flop synchronizer plus previous-value flop for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = (cnt_q == 16'd0);

    // Receiver next-state: bit timing, shifting and frame-end decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_set  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!sync2_q) begin
                        state_d = S_DATA;
                        cnt_d   = BIT_LD;
                        idx_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = BIT_LD;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = BIT_LD;
                    state_d = S_STOP;
                    if ((^shift_q) != sync2_q) begin
                        par_bad_d = 1'b1;
                        perr_set  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT_HIGH: begin
                if (sync2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) &&
                        (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop     = rd_en && !fifo_empty;
    assign do_push    = push && (!fifo_full || do_pop);
    assign ovr_set    = push && fifo_full && !do_pop;

    // FIFO storage and pointers; a pop frees the slot a same-cycle push uses.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= shift_q;
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            ferr_q <= ferr_set | (ferr_q & ~clr_err);
            ovr_q  <= ovr_set | (ovr_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
            perr_q <= perr_set | (perr_q & ~clr_err);
`endif
        end
    end

    assign rd_data    = mem_q[rd_q[AW-1:0]];
    assign rd_valid   = !fifo_empty;
    assign fifo_count = CW'(wr_q - rd_q);
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed-vector bench for uart_rx_capture (CLK_DIV=16, depth 8).
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_capture;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       ser_rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] fifo_count;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int errors = 0;
    int checks = 0;

    uart_rx_capture #(.CLK_DIV(16), .FIFO_DEPTH(8)) dut (
        .clock(clock), .resetb(resetb), .ser_rx(ser_rx),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    // Sends one frame; samples rd_valid one cycle before and just after the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input logic par_wrong, input logic pop_at_stop,
                              output logic pre_v, output logic post_v);
        @(posedge clock); #1 ser_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clock);
            #1 ser_rx = b[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (16) @(posedge clock);
        #1 ser_rx = (^b) ^ par_wrong;
`endif
        repeat (16) @(posedge clock);
        #1 ser_rx = stop_val;
        repeat (10) @(posedge clock);
        #1 pre_v = rd_valid;
        rd_en = pop_at_stop;
        @(posedge clock);
        #1 rd_en = 1'b0;
        post_v = rd_valid;
        repeat (5) @(posedge clock);
        #1 if (stop_val) ser_rx = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge clock); #1 rd_en = 1'b1;
        @(posedge clock); #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clock); #1 clr_err = 1'b1;
        @(posedge clock); #1 clr_err = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        ser_rx = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {frame_err, overrun, parity_err}); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        resetb = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic test_basic();
        logic pv, qv;
        send_frame(8'h41, 1'b1, 1'b0, 1'b0, pv, qv);
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b want 0", pv); end
        checks++; if (qv !== 1'b1) begin errors++; $display("FAIL basic_valid_on_time got %b want 1", qv); end
        checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL basic_data got %h want 41", rd_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
        pop_one();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b want 0", rd_valid); end
    endtask

    task automatic test_overrun();
        logic pv, qv;
        logic [7:0] exp_q [$];
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, pv, qv);
        end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovr_count got %0d want 8", fifo_count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ovr_head got %h want 00", rd_data); end
        pulse_clr();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
        send_frame(8'h09, 1'b1, 1'b0, 1'b1, pv, qv);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_pushpop_count got %0d want 8", fifo_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovr got %b want 0", overrun); end
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        foreach (exp_q[k]) begin
            checks++; if (rd_data !== exp_q[k]) begin errors++; $display("FAIL drain_%0d got %h want %h", k, rd_data, exp_q[k]); end
            pop_one();
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", rd_valid); end
        pop_one();
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL pop_empty_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_frame_err();
        logic pv, qv;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, pv, qv);
        repeat (32) @(posedge clock);
        #1;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", frame_err); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ferr_count got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low got %b want 1", busy); end
        ser_rx = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_hold got %b want 1", busy); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", frame_err); end
    endtask

    task automatic test_glitch();
        @(posedge clock); #1 ser_rx = 1'b0;
        repeat (4) @(posedge clock);
        #1 ser_rx = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b want 1", busy); end
        repeat (6) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b want 0", busy); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", fifo_count); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin errors++; $display("FAIL glitch_flags got %b want 000", {frame_err, overrun, parity_err}); end
    endtask

    task automatic test_mid_reset();
        logic pv, qv;
        logic [7:0] b;
        b = 8'hA5;
        @(posedge clock); #1 ser_rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (16) @(posedge clock);
            #1 ser_rx = b[i];
        end
        repeat (5) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        resetb = 1'b0;
        ser_rx = 1'b1;
        @(posedge clock);
        #1 resetb = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after got %b want 0", busy); end
        repeat (40) @(posedge clock);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, pv, qv);
        repeat (20) @(posedge clock);
        #1;
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL midrst_count got %0d want 1", fifo_count); end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL midrst_data got %h want 3c", rd_data); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {frame_err, overrun, parity_err}); end
        pop_one();
    endtask

    task automatic test_parity();
        logic pv, qv;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, pv, qv);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag got %b want 1", parity_err); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL par_bad_count got %0d want 0", fifo_count); end
        pulse_clr();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b want 0", parity_err); end
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, pv, qv);
        checks++; if (qv !== 1'b1) begin errors++; $display("FAIL par_good_valid got %b want 1", qv); end
        checks++; if (rd_data !== 8'h07) begin errors++; $display("FAIL par_good_data got %h want 07", rd_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_flag got %b want 0", parity_err); end
        pop_one();
`else
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, pv, qv);
        checks++; if (rd_data !== 8'h07) begin errors++; $display("FAIL nopar_data got %h want 07", rd_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL nopar_flag got %b want 0", parity_err); end
        pop_one();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
